// File: rtl/cache_channel_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_channel_arbiter_pkg
// Shared types and constants for the cache-side message channel arbiter.
//   arb_state_t : arbiter FSM state (IDLE = free to pick, LOCKED = mid-message)
//   NOC_N_REQ   : default requester count for a NoC request plane
//   NOC_DATA_W  : default payload width per beat for a NoC request plane
//   id_width()  : index width for n requesters, never less than one bit
// ---------------------------------------------------------------------------
package cache_channel_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int NOC_N_REQ  = 4;
  localparam int NOC_DATA_W = 64;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_channel_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// cache_channel_arbiter_rr_pick
// Combinational round-robin priority select. Returns the first asserted
// request found when scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//   req        in  N_REQ  request vector
//   rr_ptr     in  ID_W   highest-priority index for this cycle
//   grant      out N_REQ  one-hot grant (all zero when nothing requests)
//   grant_idx  out ID_W   encoded index of the granted requester
//   any_valid  out 1      at least one request is asserted
// ---------------------------------------------------------------------------
module cache_channel_arbiter_rr_pick
  import cache_channel_arbiter_pkg::*;
#(
  parameter int N_REQ = NOC_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_valid
);

  // Two copies of the request vector side by side: scanning upward from
  // rr_ptr through the doubled vector visits every requester exactly once
  // in rotated order without any modulo inside the loop.
  logic [2*N_REQ-1:0] req_dbl;
  logic [ID_W:0]      pos;
  logic [ID_W:0]      hit_pos;
  logic               found;
  logic [ID_W:0]      wrapped;

  assign req_dbl = {req, req};

  always_comb begin
    found   = 1'b0;
    hit_pos = '0;
    pos     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (ID_W+1)'(k) + {1'b0, rr_ptr};
      if (!found && (int'(pos) < 2*N_REQ) && req_dbl[pos]) begin
        found   = 1'b1;
        hit_pos = pos;
      end
    end
  end

  // A hit in the upper copy maps back to the same requester in the lower copy.
  always_comb begin
    wrapped = hit_pos;
    if (hit_pos >= (ID_W+1)'(N_REQ)) begin
      wrapped = hit_pos - (ID_W+1)'(N_REQ);
    end
  end

  assign any_valid = found;
  assign grant_idx = wrapped[ID_W-1:0];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant[gi] = found && (grant_idx == ID_W'(gi));
  end

endmodule

// File: rtl/cache_channel_arbiter.sv
// ---------------------------------------------------------------------------
// cache_channel_arbiter
// N-requester round-robin arbiter sharing one ready/valid message channel.
// The grant is held for a multi-beat message until its last beat, and the
// output is registered through a one-entry stage that can be refilled in the
// same cycle it drains, so one beat per cycle flows under continuous
// out_ready.
//   clk        in  1             clock
//   rst        in  1             asynchronous reset, active-high
//   req_valid  in  N_REQ         per-requester beat valid
//   req_ready  out N_REQ         per-requester beat accepted (at most one set)
//   req_data   in  N_REQ*DATA_W  payloads, requester i at [i*DATA_W +: DATA_W]
//   req_last   in  N_REQ         final beat of message
//   out_valid  out 1             output register holds a beat
//   out_ready  in  1             downstream accepts
//   out_data   out DATA_W        registered payload
//   out_last   out 1             registered last flag
//   out_id     out ID_W          requester index of the registered beat
//   busy       out 1             arbiter is mid-message
// ---------------------------------------------------------------------------
module cache_channel_arbiter
  import cache_channel_arbiter_pkg::*;
#(
  parameter int N_REQ  = NOC_N_REQ,
  parameter int DATA_W = NOC_DATA_W,
  parameter int ID_W   = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy
);

  arb_state_t        state_q,     state_d;
  logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [ID_W-1:0]   lock_id_q,   lock_id_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic [ID_W-1:0]   out_id_q,    out_id_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;
  logic [N_REQ-1:0]  lock_onehot;
  logic [DATA_W-1:0] req_data_arr [N_REQ];

  logic              space;
  logic              accept;
  logic [ID_W-1:0]   acc_id;
  logic [ID_W-1:0]   acc_id_next;

  cache_channel_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    assign lock_onehot[gi]  = (lock_id_q == ID_W'(gi));
  end

  // Round-robin successor of the requester currently being served.
  assign acc_id      = (state_q == LOCKED) ? lock_id_q : pick_idx;
  assign acc_id_next = (acc_id == ID_W'(N_REQ-1)) ? '0 : acc_id + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_id_d   = lock_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    req_ready   = '0;

    // The output stage can take a beat when empty or draining this cycle.
    space = !out_valid_q || out_ready;

    if (space) begin
      if (state_q == IDLE) begin
        req_ready = pick_any ? pick_grant : '0;
      end else begin
        // While locked only the owner is offered ready, even if it idles.
        req_ready = lock_onehot;
      end
    end

    accept = |(req_valid & req_ready);

    if (accept) begin
      // Overwrites a draining beat in the same edge: no bubble.
      out_valid_d = 1'b1;
      out_data_d  = req_data_arr[acc_id];
      out_last_d  = req_last[acc_id];
      out_id_d    = acc_id;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_last[acc_id]) begin
            rr_ptr_d = acc_id_next;
          end else begin
            state_d   = LOCKED;
            lock_id_d = acc_id;
          end
        end
      end
      LOCKED: begin
        if (accept && req_last[acc_id]) begin
          state_d  = IDLE;
          rr_ptr_d = acc_id_next;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_id_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_id_q   <= lock_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_cache_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_channel_arbiter
// Directed stimulus for the round-robin channel arbiter. Each scenario pushes
// its hand-ordered expected beats into a scoreboard queue; an independent
// monitor pops and compares every beat the DUT hands downstream.
// ---------------------------------------------------------------------------
module tb_cache_channel_arbiter;
  import cache_channel_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            busy;

  cache_channel_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_t = -1;
  int last_t = -1;
  int busy_cnt = 0;

  // Requester models: remaining beats, message length, position in message,
  // beat counter used to tag payloads, and a per-requester enable.
  int       rem  [N];
  int       mlen [N];
  int       pos  [N];
  int       bcnt [N];
  logic [N-1:0] en;
  logic     ordy;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk(input int i, input int b);
    return {16'hCAFE, 16'(i), 32'(b)};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int id, input int b, input bit last);
    beat_t e;
    e.id   = IW'(id);
    e.data = mk(id, b);
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic load(input int i, input int nmsg, input int len);
    rem[i]  = rem[i] + nmsg * len;
    mlen[i] = len;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) bcnt[i] = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = en[i] && (rem[i] > 0);
      req_last[i]           = (pos[i] == mlen[i] - 1);
      req_data[i*DW +: DW]  = mk(i, bcnt[i]);
    end
    out_ready = ordy;
  endtask

  // Drive at the falling edge, observe acceptance just before the rising edge.
  task automatic step();
    @(negedge clk);
    apply();
    #4;
    if (busy) busy_cnt++;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        bcnt[i]++;
        rem[i]--;
        pos[i] = (pos[i] == mlen[i] - 1) ? 0 : pos[i] + 1;
      end
    end
  endtask

  task automatic drain();
    int t;
    bit pending;
    t = 0;
    pending = 1'b1;
    while (pending && t < 300) begin
      step();
      t++;
      pending = (sb.size() > 0) || out_valid;
      for (int i = 0; i < N; i++) if (rem[i] > 0) pending = 1'b1;
    end
    if (pending) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", sb.size());
    end
  endtask

  // Monitor: pops and compares every beat transferred downstream.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (first_t < 0) first_t = cyc;
        last_t = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=id%0d expected=none", out_id);
        end else begin
          e = sb.pop_front();
          $display("beat cyc=%0d id=%0d data=%h last=%0d", cyc, out_id, out_data, out_last);
          chk("beat_id", 64'(out_id), 64'(e.id));
          chk("beat_data", out_data, e.data);
          chk("beat_last", 64'(out_last), 64'(e.last));
        end
      end
    end
  end

  initial begin : stim
    rst  = 1'b1;
    en   = '0;
    ordy = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; mlen[i] = 1; pos[i] = 0; bcnt[i] = 0;
    end
    apply();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-beat fairness: all valid, two single-beat messages each.
    en = 4'hF;
    clear_counts();
    for (int i = 0; i < N; i++) load(i, 2, 1);
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) expect_beat(i, b, 1'b1);
    first_t = -1;
    drain();
    chk("fair_back_to_back", 64'(last_t - first_t), 64'd7);

    // Message lock: move pointer to 1, then req1 sends 3 beats vs req0/req2.
    clear_counts();
    load(0, 1, 1);
    expect_beat(0, 0, 1'b1);
    drain();
    load(1, 1, 3); load(0, 1, 1); load(2, 1, 1);
    expect_beat(1, 0, 1'b0); expect_beat(1, 1, 1'b0); expect_beat(1, 2, 1'b1);
    expect_beat(2, 0, 1'b1); expect_beat(0, 1, 1'b1);
    busy_cnt = 0;
    drain();
    chk("lock_busy_cycles", 64'(busy_cnt), 64'd2);

    // Backpressure: output held 5 cycles, then released.
    clear_counts();
    ordy = 1'b0;
    load(0, 2, 1);
    expect_beat(0, 0, 1'b1); expect_beat(0, 1, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_id", 64'(out_id), 64'd0);
      chk("bp_out_data", out_data, mk(0, 0));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    ordy = 1'b1;
    first_t = -1;
    drain();
    chk("bp_release_gap", 64'(last_t - first_t), 64'd1);

    // Wrap and sparse: req3 alone, then req0 alone, then all (pointer now 1).
    clear_counts();
    load(3, 1, 1); expect_beat(3, 0, 1'b1); drain();
    load(0, 1, 1); expect_beat(0, 0, 1'b1); drain();
    for (int i = 0; i < N; i++) load(i, 1, 1);
    expect_beat(1, 0, 1'b1); expect_beat(2, 0, 1'b1);
    expect_beat(3, 1, 1'b1); expect_beat(0, 1, 1'b1);
    drain();

    // Asynchronous reset while locked on req2 with a held output beat.
    clear_counts();
    ordy = 1'b0;
    load(2, 1, 3);
    step();
    step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) begin rem[i] = 0; pos[i] = 0; end
    apply();
    @(negedge clk);
    rst  = 1'b0;
    ordy = 1'b1;
    clear_counts();
    for (int i = 0; i < N; i++) load(i, 1, 1);
    for (int i = 0; i < N; i++) expect_beat(i, 0, 1'b1);
    drain();

    // Stall while locked: req1 drops valid mid-message, req3 must wait.
    clear_counts();
    load(1, 1, 3); load(3, 1, 1);
    expect_beat(1, 0, 1'b0); expect_beat(1, 1, 1'b0); expect_beat(1, 2, 1'b1);
    expect_beat(3, 0, 1'b1);
    step();
    en[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_req3_ready", 64'(req_ready[3]), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
    end
    en[1] = 1'b1;
    drain();

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
